// File: rtl/bk_pkg.sv
// Shared constants and state type for the Brent-Kung stream accumulator.
package bk_pkg;
   localparam int BK_WIDTH = 16;
   localparam logic [BK_WIDTH-1:0] BK_SAT_VAL = 16'hFFFF;
   typedef enum logic {ACC, HOLD} bk_acc_state_t;
endpackage

// File: rtl/Brent_Kung.sv
// 16-bit combinational Brent-Kung parallel-prefix adder; carry-out is discarded.
module Brent_Kung (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] sum
);
   logic [15:0] w_g;
   logic [15:0] w_p;
   logic [15:0] w_p0;

   always_comb begin
      w_p0 = a ^ b;
      w_g  = a & b;
      w_p  = w_p0;
      // Up-sweep builds power-of-two group terms, down-sweep fills the gaps.
      for (int d = 1; d < 16; d = d * 2) begin
         for (int i = 2 * d - 1; i < 16; i = i + 2 * d) begin
            w_g[i] = w_g[i] | (w_p[i] & w_g[i-d]);
            w_p[i] = w_p[i] & w_p[i-d];
         end
      end
      for (int d = 4; d >= 1; d = d / 2) begin
         for (int i = 3 * d - 1; i < 16; i = i + 2 * d) begin
            w_g[i] = w_g[i] | (w_p[i] & w_g[i-d]);
            w_p[i] = w_p[i] & w_p[i-d];
         end
      end
      sum[0] = w_p0[0];
      for (int i = 1; i < 16; i++) begin
         sum[i] = w_p0[i] ^ w_g[i-1];
      end
   end
endmodule

// File: rtl/bk_stream_accumulator.sv
// Packet accumulator in front of the Brent-Kung adder; result valid one cycle after the last beat,
// upstream stalled while the result is held. Define SATURATE_EN to clamp the sum at 0xFFFF.
module bk_stream_accumulator
   import bk_pkg::*;
#(
   parameter  int MAX_OPS = 16,
   localparam int CW      = $clog2(MAX_OPS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BK_WIDTH-1:0] in_data,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BK_WIDTH-1:0] out_sum,
   output logic [CW-1:0]       out_count,
   output logic                out_ovf
);
   bk_acc_state_t       r_state;
   logic [BK_WIDTH-1:0] r_acc;
   logic [CW-1:0]       r_count;
   logic                r_ovf;

   logic [BK_WIDTH-1:0] w_sum_c;
   logic [BK_WIDTH-1:0] w_acc_nxt;
   logic [CW-1:0]       w_count_inc;
   logic                w_carry;
   logic                w_fire;
   logic                w_term;

   Brent_Kung u_adder (
      .a   (r_acc),
      .b   (in_data),
      .sum (w_sum_c)
   );

   // The adder has no carry-out; a wrapped unsigned sum is smaller than the accumulator.
   assign w_carry     = (w_sum_c < r_acc);
   assign w_count_inc = r_count + 1'b1;
   assign w_fire      = in_valid && (r_state == ACC);
   assign w_term      = in_last || (w_count_inc == CW'(MAX_OPS));

`ifdef SATURATE_EN
   // Once clamped, any further non-zero beat carries again, so the clamp sticks.
   assign w_acc_nxt = w_carry ? BK_SAT_VAL : w_sum_c;
`else
   assign w_acc_nxt = w_sum_c;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ACC;
         r_acc   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ACC: begin
               if (w_fire) begin
                  r_acc   <= w_acc_nxt;
                  r_count <= w_count_inc;
                  r_ovf   <= r_ovf | w_carry;
                  if (w_term) r_state <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_acc   <= '0;
                  r_count <= '0;
                  r_ovf   <= 1'b0;
                  r_state <= ACC;
               end
            end
            default: r_state <= ACC;
         endcase
      end
   end

   assign in_ready  = (r_state == ACC);
   assign out_valid = (r_state == HOLD);
   assign out_sum   = r_acc;
   assign out_count = r_count;
   assign out_ovf   = r_ovf;
endmodule

// File: tb/tb_bk_stream_accumulator.sv
// Randomized scoreboard bench for bk_stream_accumulator against an arithmetic packet model.
module tb_bk_stream_accumulator;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   out_sum;
   logic [CW-1:0] out_count;
   logic          out_ovf;

   typedef struct {
      int sum;
      int count;
      int ovf;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
   bit   held = 1'b0;
   int   hs_sum, hs_cnt, hs_ovf;

   bk_stream_accumulator #(.MAX_OPS(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Packet result from plain integer arithmetic over the whole packet.
   function automatic exp_t model(input int beats[$]);
      exp_t e;
      longint total = 0;
      foreach (beats[k]) total += beats[k];
      e.count = beats.size();
      e.ovf   = (total > 65535) ? 1 : 0;
`ifdef SATURATE_EN
      e.sum   = e.ovf ? 65535 : int'(total);
`else
      e.sum   = int'(total % 65536);
`endif
      return e;
   endfunction

   task automatic send_beat(input int data, input bit last, input bit term);
      int n = 0;
      in_valid = 1'b1;
      in_data  = 16'(data);
      in_last  = last;
      while (!in_ready && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 16'($urandom);
      if (term) chk("latency_out_valid", out_valid, 1);
   endtask

   task automatic idle(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         in_data = 16'($urandom);
         @(posedge clk); #1;
      end
   endtask

   task automatic send_packet(input int beats[$], input bit use_last, input int gap_max);
      for (int k = 0; k < beats.size(); k++) begin
         idle($urandom_range(0, gap_max));
         send_beat(beats[k], use_last && (k == beats.size() - 1), k == beats.size() - 1);
      end
      sb.push_back(model(beats));
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         exp_t e;
         chk("in_ready_in_hold", in_ready, 0);
         if (held) begin
            chk("stable_sum", out_sum, hs_sum);
            chk("stable_count", out_count, hs_cnt);
            chk("stable_ovf", out_ovf, hs_ovf);
         end
         if (out_ready) begin
            held = 1'b0;
            if (sb.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("out_sum", out_sum, e.sum);
               chk("out_count", out_count, e.count);
               chk("out_ovf", out_ovf, e.ovf);
            end
         end else if (!held) begin
            held   = 1'b1;
            hs_sum = out_sum;
            hs_cnt = out_count;
            hs_ovf = out_ovf;
         end
      end else begin
         held = 1'b0;
      end
   end

   initial begin
      int q[$];
      int n;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_out_ovf", out_ovf, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      q = '{2, 5};
      send_packet(q, 1'b1, 0);
      idle(2);

      rdy_mode = 2;
      q = '{14, 1, 15, 1, 16};
      send_packet(q, 1'b1, 0);
      idle(4);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      rdy_mode = 0;

      q = '{16'hFFF0, 16'h0011};
      send_packet(q, 1'b1, 1);
      idle(2);

      q = {};
      for (int k = 0; k < 16; k++) q.push_back(1);
      send_packet(q, 1'b0, 0);
      idle(2);

      for (int k = 0; k < 3; k++) send_beat(17, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_sum", out_sum, 0);
      chk("midrst_out_count", out_count, 0);
      chk("midrst_out_ovf", out_ovf, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      q = '{0, 0};
      send_packet(q, 1'b1, 0);
      idle(2);

      for (int p = 0; p < 40; p++) begin
         int len;
         bit use_last;
         bit big;
         rdy_mode = $urandom_range(0, 1);
         len      = $urandom_range(1, 16);
         use_last = (len < 16) ? 1'b1 : 1'($urandom_range(0, 1));
         big      = 1'($urandom_range(0, 1));
         q = {};
         for (int k = 0; k < len; k++)
            q.push_back(big ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 300)));
         send_packet(q, use_last, 2);
      end

      rdy_mode = 0;
      n = 0;
      while (sb.size() > 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      chk("drain_scoreboard", sb.size(), 0);
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
